time_keeper: RTL and testbench

Real-time-of-day source for the clock display. Divides the pixel clock down to a 1 Hz tick and keeps hours:minutes:seconds as six BCD digits in 24-hour format. Supports a button-driven set mode and publishes the time to the VGA controller once per frame so a digit never changes mid-frame. Sits directly upstream of the VGA controller and drives its `hours`/`minutes`/`seconds` digit inputs.

---
 rtl/clock_pkg.sv | 13 +
 rtl/time_keeper_bcd_pair_counter.sv | 37 +++
 rtl/time_keeper.sv | 88 ++++++++
 tb/tb_time_keeper.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared digit type, set-state encoding and BCD limits for the time keeper
package clock_pkg;
  typedef logic [3:0] bcd_t;
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2,
    SET_SEC = 2'd3
  } set_state_t;
  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;
endpackage

// File: rtl/time_keeper_bcd_pair_counter.sv
// bcd_pair_counter: two-digit BCD counter wrapping MAX->00 with clear and carry out
module bcd_pair_counter
  import clock_pkg::*;
#(
  parameter int MAX = 59
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output bcd_t tens,
  output bcd_t ones,
  output logic carry_out
);
  localparam bcd_t MAX_T = bcd_t'(MAX / 10);
  localparam bcd_t MAX_O = bcd_t'(MAX % 10);
  bcd_t tens_q, tens_d, ones_q, ones_d;
  logic at_max;
  // clear wins; otherwise step ones 0..9 and wrap the pair to 00 after MAX
  always_comb begin
    at_max    = tens_q == MAX_T && ones_q == MAX_O;
    ones_d    = clr ? '0 : !en ? ones_q : (at_max || ones_q == 4'd9) ? '0 : ones_q + 4'd1;
    tens_d    = clr ? '0 : !en ? tens_q : at_max ? '0 : ones_q == 4'd9 ? tens_q + 4'd1 : tens_q;
    carry_out = en && !clr && at_max;
  end
  // digit registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      tens_q <= '0;
      ones_q <= '0;
    end else begin
      tens_q <= tens_d;
      ones_q <= ones_d;
    end
  assign tens = tens_q;
  assign ones = ones_q;
endmodule

// File: rtl/time_keeper.sv
// time_keeper: 1 Hz prescaler, HH:MM:SS BCD time with button set mode and frame-aligned outputs
module time_keeper
  import clock_pkg::*;
#(
  parameter int CLK_HZ      = 25_000_000,
  parameter bit FRAME_ALIGN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode,
  input  logic       inc,
  input  logic       frame_sync,
  output bcd_t       hr_tens,
  output bcd_t       hr_ones,
  output bcd_t       min_tens,
  output bcd_t       min_ones,
  output bcd_t       sec_tens,
  output bcd_t       sec_ones,
  output logic       tick,
  output logic [1:0] setting
);
  localparam int PW = CLK_HZ > 1 ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] TC = PW'(CLK_HZ - 1);
  set_state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic tick_q, tick_d;
  logic inc_ok, sec_en, sec_clr, min_en, hr_en;
  logic sec_carry, min_carry, unused_day_carry;
  bcd_t ht, ho, mt, mo, st, so;
  logic [23:0] live;
  // set-state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= RUN;
    else state_q <= state_d;
  // every mode pulse steps RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN
  always_comb state_d = mode ? set_state_t'(state_q + 2'd1) : state_q;
  // field controls: tick ripples in RUN; SET states edit one field with no carry, mode masks inc
  always_comb begin
    setting = state_q;
    inc_ok  = inc && !mode;
    sec_en  = state_q == RUN && tick_q;
    sec_clr = state_q == SET_SEC && inc_ok;
  end
  assign min_en = state_q == RUN ? sec_carry : state_q == SET_MIN && inc_ok;
  assign hr_en  = state_q == RUN ? min_carry : state_q == SET_HR && inc_ok;
  // prescaler stays at 0 through any SET state and the edge returning to RUN
  always_comb begin
    presc_d = (state_q != RUN || state_d != RUN || presc_q == TC) ? '0 : presc_q + PW'(1);
    tick_d  = state_q == RUN && state_d == RUN && presc_d == TC;
  end
  // prescaler and registered tick
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      presc_q <= '0;
      tick_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tick_q  <= tick_d;
    end
  assign tick = tick_q;
  bcd_pair_counter #(.MAX(SEC_MAX)) u_sec (
    .clk(clk), .rst(rst), .en(sec_en), .clr(sec_clr),
    .tens(st), .ones(so), .carry_out(sec_carry)
  );
  bcd_pair_counter #(.MAX(MIN_MAX)) u_min (
    .clk(clk), .rst(rst), .en(min_en), .clr(1'b0),
    .tens(mt), .ones(mo), .carry_out(min_carry)
  );
  bcd_pair_counter #(.MAX(HR_MAX)) u_hr (
    .clk(clk), .rst(rst), .en(hr_en), .clr(1'b0),
    .tens(ht), .ones(ho), .carry_out(unused_day_carry)
  );
  assign live = {ht, ho, mt, mo, st, so};
  if (FRAME_ALIGN) begin : g_align
    logic [23:0] disp_q, disp_d;
    // capture the pre-edge live time on frame_sync so digits hold for a whole frame
    always_comb disp_d = frame_sync ? live : disp_q;
    // display register
    always_ff @(posedge clk or posedge rst)
      if (rst) disp_q <= '0;
      else disp_q <= disp_d;
    assign {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones} = disp_q;
  end else begin : g_live
    logic unused_fs;
    assign unused_fs = frame_sync;
    assign {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones} = live;
  end
endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: randomized and directed check of time_keeper against a seconds-of-day model
module tb_time_keeper;
  logic clk = 1'b0, rst = 1'b0, mode = 1'b0, inc = 1'b0, frame_sync = 1'b0;
  logic [3:0] l_ht, l_ho, l_mt, l_mo, l_st, l_so, a_ht, a_ho, a_mt, a_mo, a_st, a_so;
  logic l_tick, a_tick;
  logic [1:0] l_set, a_set;
  logic [23:0] lv, av;
  int n_chk = 0, n_fail = 0;
  int tod, st, rc, disp;
  bit tk;

  time_keeper #(.CLK_HZ(4), .FRAME_ALIGN(1'b0)) u_live (
    .clk(clk), .rst(rst), .mode(mode), .inc(inc), .frame_sync(frame_sync),
    .hr_tens(l_ht), .hr_ones(l_ho), .min_tens(l_mt), .min_ones(l_mo),
    .sec_tens(l_st), .sec_ones(l_so), .tick(l_tick), .setting(l_set)
  );
  time_keeper #(.CLK_HZ(4), .FRAME_ALIGN(1'b1)) u_frame (
    .clk(clk), .rst(rst), .mode(mode), .inc(inc), .frame_sync(frame_sync),
    .hr_tens(a_ht), .hr_ones(a_ho), .min_tens(a_mt), .min_ones(a_mo),
    .sec_tens(a_st), .sec_ones(a_so), .tick(a_tick), .setting(a_set)
  );

  assign lv = {l_ht, l_ho, l_mt, l_mo, l_st, l_so};
  assign av = {a_ht, a_ho, a_mt, a_mo, a_st, a_so};

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] bcd(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_reset();
    tod = 0; st = 0; rc = 0; disp = 0; tk = 1'b0;
  endtask

  task automatic model_step(input bit m, input bit i, input bit f);
    int h, mn, s, nst;
    if (f) disp = tod;
    if (tk) tod = (tod + 1) % 86400;
    else if (st != 0 && i && !m) begin
      h = tod / 3600;
      mn = (tod / 60) % 60;
      s = tod % 60;
      if (st == 1) h = (h + 1) % 24;
      else if (st == 2) mn = (mn + 1) % 60;
      else s = 0;
      tod = h * 3600 + mn * 60 + s;
    end
    nst = m ? (st + 1) % 4 : st;
    rc = (st == 0 && nst == 0) ? rc + 1 : 0;
    st = nst;
    tk = (st == 0) && (rc % 4 == 3);
  endtask

  task automatic check_all();
    chk("live", lv, bcd(tod));
    chk("frame", av, bcd(disp));
    chk("tick", 24'(l_tick), 24'(tk));
    chk("tick_f", 24'(a_tick), 24'(tk));
    chk("setting", 24'(l_set), 24'(st));
    chk("setting_f", 24'(a_set), 24'(st));
  endtask

  task automatic cyc(input bit m, input bit i, input bit f);
    mode = m; inc = i; frame_sync = f;
    @(posedge clk);
    model_step(m, i, f);
    #1;
    mode = 1'b0; inc = 1'b0; frame_sync = 1'b0;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_live", lv, 24'h0);
    chk("rst_frame", av, 24'h0);
    chk("rst_setting", 24'(l_set), 24'h0);
    chk("rst_tick", 24'(l_tick), 24'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_all();
  endtask

  initial begin
    do_reset();
    repeat (3) cyc(0, 0, 0);
    chk("first_tick", 24'(l_tick), 24'h1);
    repeat (237) cyc(0, 0, 0);
    chk("sixty_ticks", lv, 24'h000100);

    cyc(1, 0, 0);
    repeat (23) cyc(0, 1, 0);
    cyc(1, 0, 0);
    repeat (58) cyc(0, 1, 0);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(1, 0, 0);
    chk("set_2359", lv, 24'h235900);
    for (int k = 0; k < 400 && !(tod == 86399 && tk); k++) cyc(0, 0, 0);
    chk("reach_235959", lv, 24'h235959);
    cyc(0, 0, 0);
    chk("midnight", lv, 24'h000000);

    cyc(1, 0, 0);
    repeat (25) cyc(0, 1, 0);
    chk("hr_inc25", lv, 24'h010000);
    cyc(1, 0, 0);
    repeat (61) cyc(0, 1, 0);
    chk("min_inc61", lv, 24'h010100);
    cyc(1, 0, 0);
    cyc(0, 1, 0);
    chk("sec_clear", lv, 24'h010100);
    cyc(1, 0, 0);
    chk("back_to_run", 24'(l_set), 24'h0);
    repeat (3) cyc(0, 0, 0);
    chk("tick_after_set", 24'(l_tick), 24'h1);

    do_reset();
    for (int k = 0; k < 100 && !(tod == 5 && tk); k++) cyc(0, 0, 0);
    cyc(0, 0, 1);
    chk("coincide_frame", av, 24'h000005);
    chk("coincide_live", lv, 24'h000006);
    for (int k = 0; k < 2; k++) begin
      cyc(0, 0, 0);
      chk("frame_hold", av, 24'h000005);
    end
    cyc(0, 0, 1);
    chk("next_frame", av, 24'h000006);

    cyc(1, 0, 0);
    cyc(1, 1, 0);
    chk("mode_inc_setting", 24'(l_set), 24'h2);
    chk("mode_inc_hours", 24'(lv[23:16]), 24'h0);
    cyc(1, 0, 0);
    cyc(1, 0, 0);

    do_reset();
    for (int k = 0; k < 300 && tod != 56; k++) cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat (12) cyc(0, 1, 0);
    cyc(1, 0, 0);
    repeat (34) cyc(0, 1, 0);
    chk("pre_reset_time", lv, 24'h123456);
    chk("pre_reset_setting", 24'(l_set), 24'h2);
    do_reset();
    repeat (20) cyc(0, 0, 0);
    chk("resume_count", lv, 24'h000005);

    for (int k = 0; k < 2000; k++)
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
